// File: rtl/rosc_odo_pkg.sv
// Shared types and constants for the ring-oscillator odometer measurement block.
// Holds the controller state enum, the default settle time and the ROSC/CLK ratio limit.
package rosc_odo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WINDOW,
        DRAIN,
        REPORT
    } state_t;

    localparam int SETTLE_CYC_DEF = 8;

    // The synchronizer only resolves every edge when the oscillator
    // runs below f_CLK / ROSC_CLK_RATIO_MIN; faster inputs alias silently.
    localparam int ROSC_CLK_RATIO_MIN = 4;

    // Bits needed to hold the value n (at least one).
    function automatic int bits_for(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rosc_edge_sync.sv
// Synchronizer plus rising-edge detector for one asynchronous ROSC output.
// Ports: clk, rst (sync, active-high), clr (flush chain), din (async), rise (1-cycle pulse).
module rosc_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            last <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~last;

endmodule

// File: rtl/rosc_meas_ctrl.sv
// Multi-channel ROSC odometer controller: enables one oscillator, settles, counts
// its rising edges over WIN_LEN CLK cycles and reports a saturating COUNT/OVF.
// Ports: CLK, RST (sync, active-high), START, CH_SEL, WIN_LEN, ROSC_IN[NCH] in;
//        EN_VCO[NCH], BUSY, DONE, COUNT, OVF out. STRESS in only with ROSC_STRESS_EN.
// ROSC_STRESS_EN: when defined, STRESS=1 keeps every non-measured channel enabled.
module rosc_meas_ctrl
    import rosc_odo_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [SEL_W-1:0] CH_SEL,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic [NCH-1:0]   ROSC_IN,
`ifdef ROSC_STRESS_EN
    input  logic             STRESS,
`endif
    output logic [NCH-1:0]   EN_VCO,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    localparam int PH_MAX = (SETTLE_CYC > SYNC_STAGES) ? SETTLE_CYC : SYNC_STAGES;
    localparam int PH_W   = bits_for(PH_MAX);
    localparam int TMR_W  = (WIN_W > PH_W) ? WIN_W : PH_W;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_in;
    logic [WIN_W-1:0] win;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] acc;
    logic             acc_ovf;
    logic [NCH-1:0]   en_vco;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             start_ok;
    logic             rise;
    logic             stress_on;

`ifdef ROSC_STRESS_EN
    assign stress_on = STRESS;
`else
    assign stress_on = 1'b0;
`endif

    // Out-of-range selections fall back to channel 0.
    assign sel_in   = (int'(CH_SEL) >= NCH) ? '0 : CH_SEL;
    assign start_ok = START && (state == IDLE);

    // Enable pattern for a given state; under stress every channel
    // other than the measured one stays on, and all are on in IDLE.
    function automatic logic [NCH-1:0] en_mask(
        input state_t           st,
        input logic [SEL_W-1:0] s,
        input logic             strs
    );
        logic [NCH-1:0] oh;
        logic [NCH-1:0] m;
        oh = NCH'(1) << s;
        m  = (st == SETTLE || st == WINDOW || st == DRAIN) ? oh : '0;
        if (strs) begin
            m = (st == IDLE) ? '1 : (m | ~oh);
        end
        return m;
    endfunction

    // Channel mux sits ahead of a single synchronizer, flushed on START
    // so a stale level from the previous channel cannot look like an edge.
    rosc_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst  (RST),
        .clr  (start_ok),
        .din  (ROSC_IN[sel]),
        .rise (rise)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sel     <= '0;
            win     <= '0;
            tmr     <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            en_vco  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            done   <= 1'b0;
            en_vco <= en_mask(state, sel, stress_on);
            unique case (state)
                IDLE: begin
                    if (START) begin
                        state   <= SETTLE;
                        sel     <= sel_in;
                        win     <= WIN_LEN;
                        tmr     <= TMR_W'(SETTLE_CYC - 1);
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                        busy    <= 1'b1;
                        en_vco  <= en_mask(SETTLE, sel_in, stress_on);
                    end
                end
                SETTLE: begin
                    if (tmr == '0) begin
                        if (win == '0) begin
                            state <= DRAIN;
                            tmr   <= TMR_W'(SYNC_STAGES);
                        end else begin
                            state <= WINDOW;
                            tmr   <= TMR_W'(win - WIN_W'(1));
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                WINDOW: begin
                    if (rise) begin
                        if (acc == '1) begin
                            acc_ovf <= 1'b1;
                        end else begin
                            acc <= acc + CNT_W'(1);
                        end
                    end
                    if (tmr == '0) begin
                        state <= DRAIN;
                        tmr   <= TMR_W'(SYNC_STAGES);
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                DRAIN: begin
                    // Edges still in the synchronizer are discarded.
                    if (tmr == '0) begin
                        state  <= REPORT;
                        done   <= 1'b1;
                        count  <= acc;
                        ovf    <= acc_ovf;
                        en_vco <= en_mask(REPORT, sel, stress_on);
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                REPORT: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    en_vco <= en_mask(IDLE, sel, stress_on);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign EN_VCO = en_vco;
    assign BUSY   = busy;
    assign DONE   = done;
    assign COUNT  = count;
    assign OVF    = ovf;

endmodule
